// File: rtl/mux_arbiter.sv
// Round-robin arbiter for four requesters that also muxes the owner's data
// bit onto Y. An owner keeps the grant for at most HOLD_MAX consecutive
// cycles while anyone else is waiting. Ownership passes directly between
// requesters without an idle cycle in between.
module mux_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] I,
    output logic [1:0] S,
    output logic       Y,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] s_q, s_d;
    logic       y_q, y_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;

    logic [3:0] others;
    logic [2:0] pick_any;
    logic [2:0] pick_oth;

    // Returns {found, index} for the first set bit of r, searched from
    // from+1 around to from.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (r[idx] && !res[2]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // State and registered outputs; reset overrides any ownership in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'b11;
            s_q     <= '0;
            y_q     <= 1'b0;
            hold_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state decision: new grant from idle, hold, timeout handover or release
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_d      = s_q;
        hold_d   = hold_q;
        y_d      = y_q;
        others   = req & ~(4'b0001 << s_q);
        pick_any = rr_pick(req, last_q);
        pick_oth = rr_pick(others, s_q);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    s_d     = pick_any[1:0];
                    last_d  = pick_any[1:0];
                    hold_d  = 4'd1;
                end
            end
            OWN: begin
                y_d = I[s_q];
                if (req[s_q] && ((others == '0) || (hold_q < HOLD_LIM))) begin
                    if (hold_q < HOLD_LIM) begin
                        hold_d = hold_q + 4'd1;
                    end
                end else if (others != '0) begin
                    s_d    = pick_oth[1:0];
                    last_d = pick_oth[1:0];
                    hold_d = 4'd1;
                end else begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so grant, S and busy move on the same edge
    always_comb begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (state_d == OWN) begin
            grant_d = 4'b0001 << s_d;
            busy_d  = 1'b1;
        end
    end

    assign S     = s_q;
    assign Y     = y_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mux_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] I;
    logic [1:0] S;
    logic       Y;
    logic [3:0] grant;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: owner = -1 when idle
    int m_owner;
    int m_last;
    int m_cnt;
    int m_s;
    bit m_y;

    mux_arbiter #(.HOLD_MAX(HM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .I     (I),
        .S     (S),
        .Y     (Y),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic int next_in_order(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    endtask

    task automatic model_step();
        logic [3:0] rest;
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_cnt = 0; m_s = 0; m_y = 1'b0;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = next_in_order(req, m_last);
                m_last = m_owner; m_s = m_owner; m_cnt = 1;
            end
        end else begin
            m_y = I[m_owner];
            rest = req;
            rest[m_owner] = 1'b0;
            if (req[m_owner] && (rest == 4'b0000 || m_cnt < HM)) begin
                if (m_cnt < HM) m_cnt++;
            end else if (rest != 4'b0000) begin
                m_owner = next_in_order(rest, m_owner);
                m_last = m_owner; m_s = m_owner; m_cnt = 1;
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_grant;
        exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
        check("grant", int'(grant), exp_grant);
        check("S", int'(S), m_s);
        check("busy", int'(busy), (m_owner < 0) ? 0 : 1);
        check("Y", int'(Y), int'(m_y));
    endtask

    task automatic cycle(input logic rn, input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        rst_n = rn; req = r; I = d;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; I = '0;
        m_owner = -1; m_last = 3; m_cnt = 0; m_s = 0; m_y = 1'b0;

        // reset state
        cycle(1'b0, 4'b1111, 4'b1111);
        cycle(1'b0, 4'b0000, 4'b0000);
        check("rst_grant", int'(grant), 0);
        check("rst_S", int'(S), 0);
        check("rst_Y", int'(Y), 0);
        check("rst_busy", int'(busy), 0);

        // first grant and data latency
        cycle(1'b1, 4'b0001, 4'b1011);
        check("first_grant", int'(grant), 1);
        check("first_S", int'(S), 0);
        check("first_busy", int'(busy), 1);
        cycle(1'b1, 4'b0001, 4'b1011);
        check("first_Y", int'(Y), 1);

        // full rotation under constant contention
        cycle(1'b0, 4'b0000, 4'b0000);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, 4'b1111, 4'($urandom));
            check("rr_rotation", int'(grant), 1 << ((t / 4) % 4));
        end

        // release to idle and regrant
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0100, 4'b0000);
        check("own2_grant", int'(grant), 4);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("release_grant", int'(grant), 0);
        check("release_busy", int'(busy), 0);
        check("release_S", int'(S), 2);
        cycle(1'b1, 4'b0100, 4'b0000);
        check("regrant", int'(grant), 4);

        // direct handover after owner drops: 3 comes before 0 after last=1
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0010, 4'b0000);
        check("own1_grant", int'(grant), 2);
        cycle(1'b1, 4'b1001, 4'b0000);
        check("handover_grant", int'(grant), 8);
        check("handover_S", int'(S), 3);

        // data follow and timeout
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0011, 4'b0101);
        check("own0_grant", int'(grant), 1);
        cycle(1'b1, 4'b0011, 4'b0101);
        check("y_follow1", int'(Y), 1);
        cycle(1'b1, 4'b0011, 4'b1010);
        check("y_follow0", int'(Y), 0);
        cycle(1'b1, 4'b0011, 4'b1010);
        cycle(1'b1, 4'b0011, 4'b1010);
        check("timeout_grant", int'(grant), 2);
        cycle(1'b1, 4'b0011, 4'b1010);
        check("timeout_Y", int'(Y), 1);

        // reset mid-ownership
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0100, 4'b1111);
        check("pre_rst_grant", int'(grant), 4);
        cycle(1'b1, 4'b0100, 4'b1111);
        cycle(1'b0, 4'b1100, 4'b1111);
        check("midrst_grant", int'(grant), 0);
        check("midrst_S", int'(S), 0);
        check("midrst_Y", int'(Y), 0);
        check("midrst_busy", int'(busy), 0);
        cycle(1'b1, 4'b1100, 4'b1111);
        check("post_rst_grant", int'(grant), 4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic       rn;
            logic [3:0] r;
            rn = ($urandom_range(0, 63) != 0);
            r  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            cycle(rn, r, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
